gcd_datapath: RTL and testbench

Register-and-ALU datapath that executes the command strobes issued by the GCD controller and reports termination back to it. It holds the working operands and intermediate results, evaluates bigger, smaller and modulo, and runs modulo as a multi-cycle restoring division. It drives the controller's `valid_i` and stalls it through `alu_busy_o`. It sits directly below the controller; operands come from the top level.

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_datapath_if.sv | 45 ++++
 rtl/gcd_mod_unit.sv | 79 +++++++
 rtl/gcd_datapath.sv | 91 +++++++++
 tb/tb_gcd_datapath.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared constants and types for the GCD controller and datapath.
// The controller imports the same ALU mode encoding.
package gcd_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [2:0] GIVE_BACK_BIGGER  = 3'd0;
    localparam logic [2:0] GIVE_BACK_SMALLER = 3'd1;
    localparam logic [2:0] MODULO            = 3'd2;
    localparam logic [2:0] ALU_IDLE          = 3'd3;

    typedef enum logic {
        MOD_IDLE,
        MOD_DIV
    } mod_state_t;

endpackage

// File: rtl/gcd_datapath_if.sv
// Command/status bundle between the GCD controller and its datapath.
// master = controller/top side, slave = datapath side.
interface gcd_datapath_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [2:0]       alu_mode_i;
    logic             wren_zw_gross_i;
    logic             wren_zw_klein_i;
    logic             wren_zw_in_zahlen_i;
    logic             wren_erg_modulo_i;
    logic             wren_to_new_numbers_i;
    logic             zahl1_to_alu_a_i;
    logic             zahl2_to_alu_b_i;
    logic             check_for_termination_i;
    logic             alu_busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output load_i, a_i, b_i, alu_mode_i,
        output wren_zw_gross_i, wren_zw_klein_i,
        output wren_zw_in_zahlen_i, wren_erg_modulo_i,
        output wren_to_new_numbers_i,
        output zahl1_to_alu_a_i, zahl2_to_alu_b_i,
        output check_for_termination_i,
        input  alu_busy_o, valid_o, result_o
    );

    modport slave (
        input  load_i, a_i, b_i, alu_mode_i,
        input  wren_zw_gross_i, wren_zw_klein_i,
        input  wren_zw_in_zahlen_i, wren_erg_modulo_i,
        input  wren_to_new_numbers_i,
        input  zahl1_to_alu_a_i, zahl2_to_alu_b_i,
        input  check_for_termination_i,
        output alu_busy_o, valid_o, result_o
    );

endinterface

// File: rtl/gcd_mod_unit.sv
// Sequential restoring modulo: one shift-subtract step per cycle,
// WIDTH steps per operation; done pulses combinationally on the last step.
module gcd_mod_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    mod_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_next;
    logic             fits;
    logic             last;

    // One restoring step; a zero divisor always "fits", so the dividend
    // shifts through unchanged and A mod 0 = A falls out naturally.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        fits      = rem_shift >= {1'b0, dvs_q};
        rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
        rem_next  = fits ? rem_sub : rem_shift[WIDTH-1:0];
        last      = cnt_q == CW'(WIDTH - 1);
    end

    // Next state and status outputs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MOD_IDLE: if (start && !abort) state_d = MOD_DIV;
            MOD_DIV:  if (abort || last)   state_d = MOD_IDLE;
            default:  state_d = MOD_IDLE;
        endcase
        busy      = state_q == MOD_DIV;
        done      = (state_q == MOD_DIV) && last && !abort;
        remainder = rem_next;
    end

    // State register, operand latches and step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MOD_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MOD_IDLE && start && !abort) begin
                cnt_q <= '0;
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
            end else if (state_q == MOD_DIV) begin
                cnt_q <= cnt_q + CW'(1);
                rem_q <= rem_next;
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/gcd_datapath.sv
// GCD register file, bigger/smaller ALU and termination check; modulo
// runs in gcd_mod_unit and stalls all command strobes while busy.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    gcd_datapath_if.slave  bus
);

    logic [WIDTH-1:0] zahl1, zahl2;
    logic [WIDTH-1:0] zw_gross, zw_klein;
    logic [WIDTH-1:0] erg_modulo;
    logic [WIDTH-1:0] result_q;
    logic             valid_q;

    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [WIDTH-1:0] mod_rem;
    logic             mod_busy, mod_done, mod_start, idle;

    // Operand selects and bigger/smaller ALU; ties return A.
    always_comb begin
        alu_a   = bus.zahl1_to_alu_a_i ? zahl1 : '0;
        alu_b   = bus.zahl2_to_alu_b_i ? zahl2 : '0;
        alu_res = '0;
        if (bus.alu_mode_i == GIVE_BACK_BIGGER)
            alu_res = (alu_b > alu_a) ? alu_b : alu_a;
        else if (bus.alu_mode_i == GIVE_BACK_SMALLER)
            alu_res = (alu_b < alu_a) ? alu_b : alu_a;
        idle      = !mod_busy;
        mod_start = idle && !bus.load_i && bus.wren_erg_modulo_i &&
                    (bus.alu_mode_i == MODULO);
    end

    gcd_mod_unit #(.WIDTH(WIDTH)) u_mod (
        .clk       (clk),
        .rst       (rst),
        .start     (mod_start),
        .abort     (bus.load_i),
        .dividend  (alu_a),
        .divisor   (alu_b),
        .busy      (mod_busy),
        .done      (mod_done),
        .remainder (mod_rem)
    );

    // Register file: load beats strobes; strobes only act while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zahl1      <= '0;
            zahl2      <= '0;
            zw_gross   <= '0;
            zw_klein   <= '0;
            erg_modulo <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.load_i) begin
                zahl1    <= bus.a_i;
                zahl2    <= bus.b_i;
                result_q <= '0;
            end else begin
                if (mod_done)
                    erg_modulo <= mod_rem;
                if (idle) begin
                    if (bus.wren_zw_gross_i) zw_gross <= alu_res;
                    if (bus.wren_zw_klein_i) zw_klein <= alu_res;
                    if (bus.wren_to_new_numbers_i) begin
                        zahl1 <= zahl2;
                        zahl2 <= erg_modulo;
                    end else if (bus.wren_zw_in_zahlen_i) begin
                        zahl1 <= zw_gross;
                        zahl2 <= zw_klein;
                    end
                    if (bus.check_for_termination_i && erg_modulo == '0) begin
                        result_q <= zahl2;
                        valid_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.alu_busy_o = mod_busy;
    assign bus.valid_o    = valid_q;
    assign bus.result_o   = result_q;

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed bench for gcd_datapath: full GCD command sequences,
// strobes during DIV, load abort and asynchronous reset.
module tb_gcd_datapath;
    import gcd_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   n;

    gcd_datapath_if #(.WIDTH(W)) bus();

    gcd_datapath #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        bus.load_i                  = 1'b0;
        bus.alu_mode_i              = ALU_IDLE;
        bus.wren_zw_gross_i         = 1'b0;
        bus.wren_zw_klein_i         = 1'b0;
        bus.wren_zw_in_zahlen_i     = 1'b0;
        bus.wren_erg_modulo_i       = 1'b0;
        bus.wren_to_new_numbers_i   = 1'b0;
        bus.zahl1_to_alu_a_i        = 1'b0;
        bus.zahl2_to_alu_b_i        = 1'b0;
        bus.check_for_termination_i = 1'b0;
    endtask

    task automatic load_ops(input int a, input int b);
        bus.load_i = 1'b1;
        bus.a_i    = W'(a);
        bus.b_i    = W'(b);
        step();
        bus.load_i = 1'b0;
    endtask

    task automatic cmd_alu(input logic [2:0] mode, input logic g, input logic k);
        bus.zahl1_to_alu_a_i = 1'b1;
        bus.zahl2_to_alu_b_i = 1'b1;
        bus.alu_mode_i       = mode;
        bus.wren_zw_gross_i  = g;
        bus.wren_zw_klein_i  = k;
        step();
        clear_cmds();
    endtask

    task automatic start_mod();
        bus.zahl1_to_alu_a_i  = 1'b1;
        bus.zahl2_to_alu_b_i  = 1'b1;
        bus.alu_mode_i        = MODULO;
        bus.wren_erg_modulo_i = 1'b1;
        step();
        clear_cmds();
    endtask

    // Counts sampled busy cycles, bounded so a stuck busy still terminates.
    task automatic wait_mod(output int cnt);
        cnt = 0;
        while (bus.alu_busy_o && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    task automatic run_gcd(input string nm, input int a, input int b,
                           input int g, input int k, input int nrem,
                           input int r0, input int r1, input int r2,
                           input int res);
        int r;
        int cnt;
        load_ops(a, b);
        check_eq({nm, " result after load"}, bus.result_o, 0);
        cmd_alu(GIVE_BACK_BIGGER, 1'b1, 1'b0);
        check_eq({nm, " zw_gross"}, dut.zw_gross, g);
        cmd_alu(GIVE_BACK_SMALLER, 1'b0, 1'b1);
        check_eq({nm, " zw_klein"}, dut.zw_klein, k);
        bus.wren_zw_in_zahlen_i = 1'b1;
        step();
        clear_cmds();
        for (int i = 0; i < nrem; i++) begin
            r = (i == 0) ? r0 : (i == 1) ? r1 : r2;
            start_mod();
            wait_mod(cnt);
            check_eq($sformatf("%s busy cycles %0d", nm, i), cnt, W);
            check_eq($sformatf("%s remainder %0d", nm, i), dut.erg_modulo, r);
            bus.check_for_termination_i = 1'b1;
            step();
            clear_cmds();
            if (r == 0) begin
                check_eq({nm, " valid pulse"}, bus.valid_o, 1);
                check_eq({nm, " result"}, bus.result_o, res);
                step();
                check_eq({nm, " valid drops"}, bus.valid_o, 0);
                check_eq({nm, " result held"}, bus.result_o, res);
            end else begin
                check_eq($sformatf("%s no valid %0d", nm, i), bus.valid_o, 0);
                bus.wren_to_new_numbers_i = 1'b1;
                step();
                clear_cmds();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_cmds();
        bus.a_i = '0;
        bus.b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset busy", bus.alu_busy_o, 0);
        check_eq("reset valid", bus.valid_o, 0);
        check_eq("reset result", bus.result_o, 0);
        rst = 1'b0;
        step();

        run_gcd("g48_18", 48, 18, 48, 18, 3, 12, 6, 0, 6);
        run_gcd("g17_5", 17, 5, 17, 5, 3, 2, 1, 0, 1);
        run_gcd("g0_7", 0, 7, 7, 0, 2, 7, 0, 0, 7);
        run_gcd("g0_0", 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Strobes during DIV must be ignored: 20 mod 6 = 2, zw_gross stays 20.
        load_ops(20, 6);
        cmd_alu(GIVE_BACK_BIGGER, 1'b1, 1'b0);
        cmd_alu(GIVE_BACK_SMALLER, 1'b0, 1'b1);
        bus.wren_zw_in_zahlen_i = 1'b1;
        step();
        clear_cmds();
        start_mod();
        repeat (3) step();
        bus.zahl2_to_alu_b_i = 1'b1;
        bus.alu_mode_i       = GIVE_BACK_BIGGER;
        bus.wren_zw_gross_i  = 1'b1;
        repeat (2) step();
        clear_cmds();
        wait_mod(n);
        check_eq("strobe div remaining busy", n, 11);
        check_eq("strobe div zw_gross", dut.zw_gross, 20);
        check_eq("strobe div remainder", dut.erg_modulo, 2);

        // Load aborts DIV: erg_modulo keeps 2.
        load_ops(100, 7);
        start_mod();
        repeat (5) step();
        load_ops(9, 4);
        check_eq("abort busy", bus.alu_busy_o, 0);
        check_eq("abort zahl1", dut.zahl1, 9);
        check_eq("abort zahl2", dut.zahl2, 4);
        check_eq("abort erg", dut.erg_modulo, 2);
        check_eq("abort result", bus.result_o, 0);
        repeat (20) step();
        check_eq("abort erg later", dut.erg_modulo, 2);

        // Asynchronous reset mid-DIV with a held nonzero result.
        run_gcd("g48_18b", 48, 18, 48, 18, 3, 12, 6, 0, 6);
        start_mod();
        step();
        check_eq("pre-rst busy", bus.alu_busy_o, 1);
        check_eq("pre-rst result", bus.result_o, 6);
        #2 rst = 1'b1;
        #1;
        check_eq("async rst busy", bus.alu_busy_o, 0);
        check_eq("async rst valid", bus.valid_o, 0);
        check_eq("async rst result", bus.result_o, 0);
        check_eq("async rst zahl1", dut.zahl1, 0);
        #2 rst = 1'b0;
        step();
        check_eq("post-rst busy", bus.alu_busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
